// File: rtl/gate_delay_meter.sv
// Propagation-delay monitor for a 2-input AND cell: counts cycles from an input edge until the
// observed output follows, and keeps rise/fall last/min/max/count statistics.
module gate_delay_meter #(
  parameter int unsigned CNT_W   = 8,
  parameter int unsigned MAX_DLY = 255,
  parameter int unsigned EVT_W   = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_en,
  input  logic             i_clr,
  input  logic             i_in_a,
  input  logic             i_in_b,
  input  logic             i_dut_z,
  output logic             o_busy,
  output logic             o_meas_valid,
  output logic             o_meas_is_rise,
  output logic [CNT_W-1:0] o_rise_last,
  output logic [CNT_W-1:0] o_rise_min,
  output logic [CNT_W-1:0] o_rise_max,
  output logic [CNT_W-1:0] o_fall_last,
  output logic [CNT_W-1:0] o_fall_min,
  output logic [CNT_W-1:0] o_fall_max,
  output logic [EVT_W-1:0] o_rise_cnt,
  output logic [EVT_W-1:0] o_fall_cnt,
  output logic [EVT_W-1:0] o_abort_cnt,
  output logic             o_timeout_err
);

  localparam logic [1:0]       StIdle     = 2'd0;
  localparam logic [1:0]       StWaitRise = 2'd1;
  localparam logic [1:0]       StWaitFall = 2'd2;
  localparam logic [CNT_W-1:0] CntMax     = CNT_W'(MAX_DLY);
  localparam logic [CNT_W-1:0] DlyOnes    = '1;
  localparam logic [EVT_W-1:0] EvtOnes    = '1;

  logic [1:0]       r_state;
  logic [CNT_W-1:0] r_cnt;
  logic             r_exp_q;
  logic             r_meas_valid;
  logic             r_meas_is_rise;
  logic [CNT_W-1:0] r_rise_last, r_rise_min, r_rise_max;
  logic [CNT_W-1:0] r_fall_last, r_fall_min, r_fall_max;
  logic [EVT_W-1:0] r_rise_cnt, r_fall_cnt, r_abort_cnt;
  logic             r_timeout_err;

  logic             w_exp;
  logic             w_target;
  logic             w_start;
  logic             w_rec;
  logic             w_rec_rise;
  logic [CNT_W-1:0] w_rec_dly;
  logic             w_abort;
  logic             w_timeout;
  logic [1:0]       w_state_d;
  logic [CNT_W-1:0] w_cnt_d;

  assign w_exp    = i_in_a & i_in_b;
  assign w_target = (r_state == StWaitRise);

  always_comb begin
    w_start    = 1'b0;
    w_rec      = 1'b0;
    w_rec_rise = 1'b0;
    w_rec_dly  = '0;
    w_abort    = 1'b0;
    w_timeout  = 1'b0;
    w_state_d  = r_state;
    w_cnt_d    = r_cnt;

    if (r_state == StIdle) begin
      w_start = i_en && (w_exp != r_exp_q);
    end else if (i_en && (w_exp != w_target)) begin
      // Retrigger beats timeout; a same-cycle match still closes the old measurement.
      if (i_dut_z == w_target) begin
        w_rec      = 1'b1;
        w_rec_rise = w_target;
        w_rec_dly  = r_cnt;
      end else begin
        w_abort = 1'b1;
      end
      w_start = 1'b1;
    end else if (i_dut_z == w_target) begin
      w_rec      = 1'b1;
      w_rec_rise = w_target;
      w_rec_dly  = r_cnt;
      w_state_d  = StIdle;
      w_cnt_d    = '0;
    end else if (r_cnt == CntMax) begin
      w_timeout = 1'b1;
      w_state_d = StIdle;
      w_cnt_d   = '0;
    end else begin
      w_cnt_d = r_cnt + CNT_W'(1);
    end

    if (w_start) begin
      if (i_dut_z == w_exp) begin
        w_rec      = 1'b1;
        w_rec_rise = w_exp;
        w_rec_dly  = '0;
        w_state_d  = StIdle;
        w_cnt_d    = '0;
      end else begin
        w_state_d = w_exp ? StWaitRise : StWaitFall;
        w_cnt_d   = CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state        <= StIdle;
      r_cnt          <= '0;
      r_exp_q        <= 1'b0;
      r_meas_valid   <= 1'b0;
      r_meas_is_rise <= 1'b0;
      r_rise_last    <= '0;
      r_rise_min     <= DlyOnes;
      r_rise_max     <= '0;
      r_fall_last    <= '0;
      r_fall_min     <= DlyOnes;
      r_fall_max     <= '0;
      r_rise_cnt     <= '0;
      r_fall_cnt     <= '0;
      r_abort_cnt    <= '0;
      r_timeout_err  <= 1'b0;
    end else if (i_clr) begin
      r_state       <= StIdle;
      r_cnt         <= '0;
      r_exp_q       <= w_exp;
      r_meas_valid  <= 1'b0;
      r_rise_last   <= '0;
      r_rise_min    <= DlyOnes;
      r_rise_max    <= '0;
      r_fall_last   <= '0;
      r_fall_min    <= DlyOnes;
      r_fall_max    <= '0;
      r_rise_cnt    <= '0;
      r_fall_cnt    <= '0;
      r_abort_cnt   <= '0;
      r_timeout_err <= 1'b0;
    end else begin
      r_state      <= w_state_d;
      r_cnt        <= w_cnt_d;
      r_exp_q      <= w_exp;
      r_meas_valid <= w_rec;
      if (w_rec) begin
        r_meas_is_rise <= w_rec_rise;
        if (w_rec_rise) begin
          r_rise_last <= w_rec_dly;
          if (w_rec_dly < r_rise_min) r_rise_min <= w_rec_dly;
          if (w_rec_dly > r_rise_max) r_rise_max <= w_rec_dly;
          if (r_rise_cnt != EvtOnes) r_rise_cnt <= r_rise_cnt + EVT_W'(1);
        end else begin
          r_fall_last <= w_rec_dly;
          if (w_rec_dly < r_fall_min) r_fall_min <= w_rec_dly;
          if (w_rec_dly > r_fall_max) r_fall_max <= w_rec_dly;
          if (r_fall_cnt != EvtOnes) r_fall_cnt <= r_fall_cnt + EVT_W'(1);
        end
      end
      if (w_abort && (r_abort_cnt != EvtOnes)) r_abort_cnt <= r_abort_cnt + EVT_W'(1);
      if (w_timeout) r_timeout_err <= 1'b1;
    end
  end

  assign o_busy         = (r_state != StIdle);
  assign o_meas_valid   = r_meas_valid;
  assign o_meas_is_rise = r_meas_is_rise;
  assign o_rise_last    = r_rise_last;
  assign o_rise_min     = r_rise_min;
  assign o_rise_max     = r_rise_max;
  assign o_fall_last    = r_fall_last;
  assign o_fall_min     = r_fall_min;
  assign o_fall_max     = r_fall_max;
  assign o_rise_cnt     = r_rise_cnt;
  assign o_fall_cnt     = r_fall_cnt;
  assign o_abort_cnt    = r_abort_cnt;
  assign o_timeout_err  = r_timeout_err;

endmodule

// File: doc/gate_delay_meter.md
Name: gate_delay_meter

Overview:
- Cycle-accurate propagation-delay monitor for a 2-input AND cell under SDF-annotated simulation and on-board characterisation.
- Watches the cell's input pair, computes the expected output, and counts clock cycles until the observed output follows.
- Keeps separate rise and fall statistics (last/min/max/count), plus timeout and aborted-measurement reporting.
- Sits beside the cell under test in the delay-characterisation harness. All inputs are synchronous to clk.

Parameters:
- CNT_W, 8, width of delay values and the cycle counter.
- MAX_DLY, 255, cycles without a match before timeout; must be ≤ 2^CNT_W-1.
- EVT_W, 16, width of the event counters.

Ports:
- clk  input  1  measurement clock
- rst_n  input  1  asynchronous active-low reset
- en  input  1  measurement enable; when low, no new measurement starts and exp_q keeps tracking
- clr  input  1  synchronous statistics clear
- in_a  input  1  cell input A
- in_b  input  1  cell input B
- dut_z  input  1  observed cell output
- busy  output  1  high in WAIT_RISE/WAIT_FALL
- meas_valid  output  1  one-cycle pulse when a delay is recorded
- meas_is_rise  output  1  edge type of the last recorded measurement
- rise_last, rise_min, rise_max  output  CNT_W  rise delay statistics
- fall_last, fall_min, fall_max  output  CNT_W  fall delay statistics
- rise_cnt, fall_cnt, abort_cnt  output  EVT_W  event counters, saturating
- timeout_err  output  1  sticky; set on any timeout

Behaviour:
- exp = in_a & in_b. exp_q is exp registered.
- An edge is detected in cycle t when en=1 and exp != exp_q. The target is exp at t.
- States:
  - IDLE: on an edge with dut_z==target, record delay 0 in the same cycle (meas_valid at t+1). Otherwise go to WAIT_RISE (target=1) or WAIT_FALL (target=0) and set cnt=1.
  - WAIT_*: each cycle, if dut_z==target, record cnt and return to IDLE. Otherwise cnt++.
  - WAIT_* timeout: if cnt==MAX_DLY with no match, set timeout_err, return to IDLE, record nothing, leave counters unchanged.
- Delay definition: cycles from the edge-detect cycle to the first cycle in which dut_z==target is sampled.
- Recording:
  - Update *_last.
  - *_min = min(*_min, d); *_max = max(*_max, d).
  - Increment *_cnt, saturating at all-ones.
  - Pulse meas_valid for one cycle and set meas_is_rise.
- Retrigger while in WAIT_* with exp != target:
  - If dut_z==target in that cycle, record the measurement first, then start a new one.
  - Otherwise increment abort_cnt (saturating) and start a new measurement for the new target at this cycle (delay-0 check applies).
  - Timeout and retrigger in the same cycle: retrigger wins, no timeout.
- en deasserted mid-WAIT: the measurement continues to completion or timeout. en gates only new starts.
- clr:
  - Clears last/max to 0, min to all-ones, counts to 0, timeout_err to 0.
  - Forces IDLE and loads exp_q with current exp.
  - No meas_valid in that cycle. clr has priority over all other actions.
- Reset (rst_n low, asynchronous):
  - State IDLE, exp_q=0, cnt=0, busy=0, meas_valid=0, meas_is_rise=0.
  - last/max=0, min=all-ones, counts=0, timeout_err=0.
- Release from reset: if exp=1 in the first cycle, this is a rise edge.

Test Plan:
- Reset with in_a=in_b=0 → all outputs at reset values, rise_min=8'hFF, busy=0.
- in_a=1, in_b 0→1 at cycle t, dut_z rises at t+3 → meas_valid at t+4, rise_last=3, rise_min=rise_max=3, rise_cnt=1.
- From exp=1: in_b→0, dut_z falls 2 cycles later → fall_last=2. Repeat with 5 → fall_min=2, fall_max=5, fall_cnt=2.
- Edge with dut_z already equal to target → delay 0 recorded; edge held with dut_z stuck at 0 for 255 cycles → timeout_err=1, busy=0, rise_cnt unchanged.
- 1-cycle exp pulse 0→1→0 with dut_z stuck at 0 → abort_cnt=1. The fall target is satisfied immediately, so fall_last=0 and fall_cnt=1.
- clr asserted mid-WAIT_RISE → busy=0 next cycle, all statistics at clear values, no meas_valid. A late dut_z rise is then ignored.
